scalar_fetch_unit: RTL

//  Instruction fetch/issue stage feeding the scalar control-unit decoder: it produces the op/inst/VF/memF fields the decoder consumes.

---
 rtl/scalar_fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/scalar_fetch_unit.sv
// Scalar fetch/issue stage: PC generation, credit-limited imem requests, in-order
// response capture into a prefetch FIFO, and valid/ready issue to the decoder.
module scalar_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                INSTR_W    = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redir_en,
    input  logic [ADDR_W-1:0]  redir_pc,
    input  logic               stall,
    input  logic               dec_ready,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [1:0]         dec_op,
    output logic [1:0]         dec_inst,
    output logic               dec_vf,
    output logic               dec_memf
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W / 8);

    logic [ADDR_W-1:0]  pcReg;
    logic [CNT_W-1:0]   outstandingReg;
    logic [CNT_W-1:0]   outstandingNext;
    logic [CNT_W-1:0]   dropReg;
    logic [CNT_W-1:0]   fifoCountReg;
    logic [PTR_W-1:0]   fifoWrPtrReg;
    logic [PTR_W-1:0]   fifoRdPtrReg;
    logic [PTR_W-1:0]   aqWrPtrReg;
    logic [PTR_W-1:0]   aqRdPtrReg;

    logic [INSTR_W-1:0] fifoInstr [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifoPc    [FIFO_DEPTH];
    logic [ADDR_W-1:0]  aqAddr    [FIFO_DEPTH];

    logic creditOk;
    logic grant;
    logic resp;
    logic dropResp;
    logic push;
    logic pop;

    // Credits count both buffered words and every in-flight response, stale or not,
    // so a response can always be written without overflowing the FIFO.
    assign creditOk = ({1'b0, fifoCountReg} + {1'b0, outstandingReg}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign imem_req = rst && !stall && !redir_en && creditOk;
    assign imem_addr = pcReg;
    assign grant = imem_req && imem_gnt;

    // A response with nothing outstanding (e.g. one straddling a reset) is ignored.
    assign resp     = imem_rvalid && (outstandingReg != '0);
    assign dropResp = resp && (dropReg != '0);
    assign push     = resp && (dropReg == '0);

    assign dec_valid = (fifoCountReg != '0);
    assign pop       = dec_valid && dec_ready;

    assign dec_instr = dec_valid ? fifoInstr[fifoRdPtrReg] : '0;
    assign dec_pc    = dec_valid ? fifoPc[fifoRdPtrReg] : '0;
    assign dec_op    = dec_instr[INSTR_W-1:INSTR_W-2];
    assign dec_inst  = dec_instr[INSTR_W-3:INSTR_W-4];
    assign dec_vf    = dec_instr[INSTR_W-5];
    assign dec_memf  = dec_instr[INSTR_W-6];

    assign outstandingNext = outstandingReg + CNT_W'(grant) - CNT_W'(resp);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcReg          <= RESET_PC;
            outstandingReg <= '0;
            dropReg        <= '0;
            fifoCountReg   <= '0;
            fifoWrPtrReg   <= '0;
            fifoRdPtrReg   <= '0;
            aqWrPtrReg     <= '0;
            aqRdPtrReg     <= '0;
        end else begin
            outstandingReg <= outstandingNext;
            if (redir_en) begin
                // Everything still in flight belongs to the abandoned path.
                pcReg        <= redir_pc;
                dropReg      <= outstandingNext;
                fifoCountReg <= '0;
                fifoWrPtrReg <= '0;
                fifoRdPtrReg <= '0;
                aqWrPtrReg   <= '0;
                aqRdPtrReg   <= '0;
            end else begin
                if (grant) begin
                    pcReg      <= pcReg + PC_STEP;
                    aqWrPtrReg <= aqWrPtrReg + 1'b1;
                end
                if (dropResp) begin
                    dropReg <= dropReg - 1'b1;
                end
                if (push) begin
                    fifoWrPtrReg <= fifoWrPtrReg + 1'b1;
                    aqRdPtrReg   <= aqRdPtrReg + 1'b1;
                end
                if (pop) begin
                    fifoRdPtrReg <= fifoRdPtrReg + 1'b1;
                end
                fifoCountReg <= fifoCountReg + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !redir_en && grant) begin
            aqAddr[aqWrPtrReg] <= pcReg;
        end
        if (rst && !redir_en && push) begin
            fifoInstr[fifoWrPtrReg] <= imem_rdata;
            fifoPc[fifoWrPtrReg]    <= aqAddr[aqRdPtrReg];
        end
    end
endmodule
